// File: rtl/lib_cpu_pkg.sv
// Shared TD4 program-memory types: word count, instruction byte and loader states.
package lib_cpu;
    localparam int PROG_WORDS = 16;
    localparam int PROG_AW    = 4;

    typedef logic [7:0] INSTR;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CKSUM,
        DONE,
        ERROR
    } LOAD_STATE;
endpackage

// File: rtl/mem_bus_if.sv
// Instruction-fetch bus between the TD4 core (master) and program memory (slave).
interface mem_bus_if;
    import lib_cpu::*;

    logic [PROG_AW-1:0] addr;
    INSTR               data;

    modport master (output addr, input data);
    modport slave  (input addr, output data);
endinterface

// File: rtl/prog_loader.sv
// Byte-stream loader FSM for prog_mem: write strobes, handshake and core reset.
// Optional trailing checksum byte when PROG_MEM_CHECKSUM_EN is defined.
module prog_loader
    import lib_cpu::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic               load_valid,
    input  INSTR               load_data,
    output logic               load_ready,
    output logic               load_done,
    output logic               load_error,
    output logic               cpu_rst_n,
    output logic               we,
    output logic [PROG_AW-1:0] waddr,
    output INSTR               wdata
);
    LOAD_STATE          state_reg, state_next;
    logic [PROG_AW-1:0] cnt_reg, cnt_next;
    logic               load_done_reg;
    logic               cpu_rst_n_reg;
    logic               accept;
`ifdef PROG_MEM_CHECKSUM_EN
    INSTR               sum_reg, sum_next;
    logic               load_error_reg;
`endif

    assign load_ready = ((state_reg == LOAD) || (state_reg == CKSUM)) && !load_start;
    assign accept     = load_valid && load_ready;

    assign we    = accept && (state_reg == LOAD);
    assign waddr = cnt_reg;
    assign wdata = load_data;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
`ifdef PROG_MEM_CHECKSUM_EN
        sum_next   = sum_reg;
`endif
        // A start request wins from every state, including mid-load restarts.
        if (load_start) begin
            state_next = LOAD;
            cnt_next   = '0;
`ifdef PROG_MEM_CHECKSUM_EN
            sum_next   = '0;
`endif
        end else if (accept) begin
            if (state_reg == LOAD) begin
                cnt_next = cnt_reg + 1'b1;
`ifdef PROG_MEM_CHECKSUM_EN
                sum_next = sum_reg + load_data;
                if (cnt_reg == PROG_AW'(PROG_WORDS - 1)) state_next = CKSUM;
`else
                if (cnt_reg == PROG_AW'(PROG_WORDS - 1)) state_next = DONE;
`endif
            end
`ifdef PROG_MEM_CHECKSUM_EN
            else begin
                state_next = (INSTR'(sum_reg + load_data) == '0) ? DONE : ERROR;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            load_done_reg  <= 1'b0;
            cpu_rst_n_reg  <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
            sum_reg        <= '0;
            load_error_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            load_done_reg  <= (state_next == DONE);
            cpu_rst_n_reg  <= (state_next == IDLE) || (state_next == DONE);
`ifdef PROG_MEM_CHECKSUM_EN
            sum_reg        <= sum_next;
            load_error_reg <= (state_next == ERROR);
`endif
        end
    end

    assign load_done = load_done_reg;
    assign cpu_rst_n = cpu_rst_n_reg;
`ifdef PROG_MEM_CHECKSUM_EN
    assign load_error = load_error_reg;
`else
    assign load_error = 1'b0;
`endif
endmodule

// File: rtl/prog_mem.sv
// TD4 program memory: 16 x 8 store with combinational fetch and a run-time loader.
// Define PROG_MEM_CHECKSUM_EN to require a trailing checksum byte per load.
module prog_mem
    import lib_cpu::*;
#(
    parameter int WORDS = PROG_WORDS
)
(
    input  logic      clk,
    input  logic      rst_n,
    mem_bus_if.slave  mem_bus,
    input  logic      load_start,
    input  logic      load_valid,
    input  INSTR      load_data,
    output logic      load_ready,
    output logic      load_done,
    output logic      load_error,
    output logic      cpu_rst_n
);
    INSTR               mem [WORDS];
    logic               we;
    logic [PROG_AW-1:0] waddr;
    INSTR               wdata;

    prog_loader u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .load_error (load_error),
        .cpu_rst_n  (cpu_rst_n),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata)
    );

    // Cleared on reset so a reset mid-load never leaves a half-written program.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign mem_bus.data = mem[mem_bus.addr];
endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: spec-level model checked every cycle plus literal spot checks.
module tb_prog_mem;
    import lib_cpu::*;

`ifdef PROG_MEM_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int NB = CK ? 17 : 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_ready, load_done, load_error, cpu_rst_n;

    mem_bus_if bus ();

    int vectors = 0;
    int miscompares = 0;
    int rdy_cnt = 0;

    always #5 clk = ~clk;

    prog_mem #(.WORDS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_bus    (bus),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .load_error (load_error),
        .cpu_rst_n  (cpu_rst_n)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: program image, bytes received in the current load, outcome flags.
    logic [7:0] m_mem [16];
    bit  m_valid = 0, m_loading = 0, m_done = 0, m_err = 0, m_run = 0;
    int  m_n = 0;

    always @(posedge clk) begin
        int tot;
        m_valid = 1;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_loading = 0; m_n = 0; m_done = 0; m_err = 0; m_run = 0;
        end else begin
            if (load_start) begin
                m_loading = 1; m_n = 0; m_done = 0; m_err = 0;
            end else if (m_loading && load_valid) begin
                if (m_n < 16) m_mem[m_n] = load_data;
                m_n++;
                if (m_n == NB) begin
                    m_loading = 0;
                    tot = 0;
                    for (int i = 0; i < 16; i++) tot += int'(m_mem[i]);
                    if (CK) tot += int'(load_data);
                    if (CK && (tot % 256) != 0) m_err = 1;
                    else m_done = 1;
                end
            end
            m_run = !m_loading && !m_err;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("data", bus.data, m_mem[bus.addr]);
            chk("load_ready", {7'b0, load_ready}, {7'b0, m_loading && !load_start});
            chk("load_done", {7'b0, load_done}, {7'b0, m_done});
            chk("load_error", {7'b0, load_error}, {7'b0, m_err});
            chk("cpu_rst_n", {7'b0, cpu_rst_n}, {7'b0, m_run});
        end
    end

    task automatic tick(input bit st, input bit vl, input logic [7:0] d);
        load_start = st; load_valid = vl; load_data = d;
        #1;
        if (load_ready) rdy_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic peek(input int a, input logic [7:0] exp, input string name);
        load_start = 0; load_valid = 0;
        bus.addr = 4'(a);
        #1;
        chk(name, bus.data, exp);
        @(posedge clk); #1;
    endtask

    task automatic send_data(input logic [7:0] base, input int step, input bit gapped);
        for (int i = 0; i < 16; i++) begin
            if (gapped) tick(0, 0, 8'hEE);
            tick(0, 1, 8'(int'(base) + step * i));
        end
    endtask

    function automatic logic [7:0] good_ck(input logic [7:0] base, input int step);
        int s = 0;
        for (int i = 0; i < 16; i++) s += (int'(base) + step * i) % 256;
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic wait_done();
        int k;
        for (k = 0; k < 4; k++) begin
            if (load_done) break;
            tick(0, 0, 8'h00);
        end
        vectors++;
        if (k == 4) begin
            miscompares++;
            $display("FAIL wait_done: got timeout expected load_done=1");
        end
    endtask

    initial begin
        bus.addr = 4'd0;
        // Reset for two cycles, then release
        rst_n = 0;
        tick(0, 0, 8'h00);
        tick(0, 0, 8'h00);
        rst_n = 1;
        tick(0, 0, 8'h00);
        chk("reset_cpu_rst_n", {7'b0, cpu_rst_n}, 8'h01);
        chk("reset_load_done", {7'b0, load_done}, 8'h00);
        for (int a = 0; a < 16; a++) peek(a, 8'h00, "reset_sweep");

        // Full load 30..3F
        tick(1, 0, 8'h00);
        rdy_cnt = 0;
        send_data(8'h30, 1, 0);
        chk("full_ready_cycles", 8'(rdy_cnt), 8'd16);
        if (CK) tick(0, 1, good_ck(8'h30, 1));
        chk("full_ck_literal", good_ck(8'h30, 1), 8'h88);
        wait_done();
        chk("full_load_done", {7'b0, load_done}, 8'h01);
        chk("full_cpu_rst_n", {7'b0, cpu_rst_n}, 8'h01);
        peek(5, 8'h35, "full_mem5");

        // Gapped valid, same stream
        tick(1, 0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            tick(0, 0, 8'hEE);
            if (i == 15) chk("gap_cpu_rst_n_held", {7'b0, cpu_rst_n}, 8'h00);
            tick(0, 1, 8'(8'h30 + i));
        end
        if (CK) tick(0, 1, 8'h88);
        wait_done();
        peek(10, 8'h3A, "gap_mem10");
        peek(15, 8'h3F, "gap_mem15");

        // Restart after 7 bytes; the byte offered with load_start is dropped
        tick(1, 0, 8'h00);
        for (int i = 0; i < 7; i++) tick(0, 1, 8'(8'h50 + i));
        tick(1, 1, 8'h99);
        send_data(8'hA0, 1, 0);
        if (CK) tick(0, 1, good_ck(8'hA0, 1));
        wait_done();
        peek(0, 8'hA0, "restart_mem0");
        peek(6, 8'hA6, "restart_mem6");

`ifdef PROG_MEM_CHECKSUM_EN
        // Checksum pass then fail on an all-01 program
        tick(1, 0, 8'h00);
        send_data(8'h01, 0, 0);
        tick(0, 1, 8'hF0);
        chk("ck_pass_done", {7'b0, load_done}, 8'h01);
        tick(1, 0, 8'h00);
        send_data(8'h01, 0, 0);
        tick(0, 1, 8'hF1);
        tick(0, 0, 8'h00);
        chk("ck_fail_error", {7'b0, load_error}, 8'h01);
        chk("ck_fail_cpu_rst_n", {7'b0, cpu_rst_n}, 8'h00);
        tick(1, 0, 8'h00);
        chk("ck_restart_clears_error", {7'b0, load_error}, 8'h00);
        tick(1, 0, 8'h00);
        send_data(8'h30, 1, 0);
        tick(0, 1, 8'h88);
`endif

        // Reset in the middle of a load
        tick(1, 0, 8'h00);
        for (int i = 0; i < 9; i++) tick(0, 1, 8'(8'hC0 + i));
        rst_n = 0;
        tick(0, 1, 8'h77);
        chk("midrst_load_ready", {7'b0, load_ready}, 8'h00);
        peek(0, 8'h00, "midrst_mem0");
        peek(8, 8'h00, "midrst_mem8");
        peek(15, 8'h00, "midrst_mem15");
        rst_n = 1;
        tick(0, 0, 8'h00);
        chk("midrst_cpu_rst_n", {7'b0, cpu_rst_n}, 8'h01);
        tick(0, 0, 8'h00);

        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
